// File: rtl/tagger_edge_generator_if.sv
// tagger_edge_generator_if
//   Request channel into the edge generator. The producer schedules one
//   line edge per transfer: the coarse slot, the sample index inside that
//   slot and the line level from that sample onward.
//   req_valid / req_ready : valid/ready handshake, accepted when both high
//   req_time              : coarse slot of the edge (TIME_BITS)
//   req_subtime           : sample index within the slot (BITS)
//   req_level             : line level from the edge onward
interface tagger_edge_generator_if #(
  parameter int BITS      = 3,
  parameter int TIME_BITS = 16
);
  logic                 req_valid;
  logic                 req_ready;
  logic [TIME_BITS-1:0] req_time;
  logic [BITS-1:0]      req_subtime;
  logic                 req_level;

  modport master (output req_valid, req_time, req_subtime, req_level,
                  input  req_ready);
  modport slave  (input  req_valid, req_time, req_subtime, req_level,
                  output req_ready);
endinterface

// File: rtl/tagger_edge_generator.sv
// tagger_edge_generator
//   Queues scheduled edge requests and, at the scheduled coarse slot, emits
//   one serializer word of N = 1<<BITS samples (bit 0 earliest).
//   Ports:
//     clk, rst_n   : clock, asynchronous active-low reset
//     req          : request channel (slave side of tagger_edge_generator_if)
//     time_now     : free-running coarse counter
//     samples      : sample word for the slot before time_now
//     line_level   : level at the end of the current word
//     late         : one-cycle pulse, head request missed its slot
//     fifo_count   : queue occupancy
//   Build option: define TAGGER_EDGE_GEN_LATE_APPLY_EN to apply a late head
//   at subtime 0 of the current slot; otherwise a late head is dropped.

// One sample lane: takes the new level at or after the edge subtime.
module tagger_edge_gen_lane #(
  parameter int BITS = 3,
  parameter int LANE = 0
) (
  input  logic [BITS-1:0] subtime,
  input  logic            edge_level,
  input  logic            prev_level,
  output logic            sample
);
  localparam logic [BITS:0] LANE_IDX = LANE[BITS:0];
  assign sample = ({1'b0, subtime} <= LANE_IDX) ? edge_level : prev_level;
endmodule

module tagger_edge_generator #(
  parameter int BITS       = 3,
  parameter int TIME_BITS  = 16,
  parameter int DEPTH_LOG2 = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  tagger_edge_generator_if.slave req,
  output logic [TIME_BITS-1:0]  time_now,
  output logic [(1<<BITS)-1:0]  samples,
  output logic                  line_level,
  output logic                  late,
  output logic [DEPTH_LOG2:0]   fifo_count
);
  localparam int N     = 1 << BITS;
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   FULL_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [DEPTH_LOG2:0]   CNT_ONE  = {{DEPTH_LOG2{1'b0}}, 1'b1};
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};
  localparam logic [TIME_BITS-1:0]  TIME_ONE = {{(TIME_BITS-1){1'b0}}, 1'b1};

  typedef struct packed {
    logic [TIME_BITS-1:0] t;
    logic [BITS-1:0]      sub;
    logic                 lvl;
  } entry_t;

  entry_t                  mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]     count_q, count_d;
  logic                    push_q, push_d;
  logic [TIME_BITS-1:0]    time_q, time_d;
  logic [N-1:0]            samples_q, samples_d;
  logic                    line_q, line_d;
  logic                    late_q, late_d;

  entry_t                  head;
  logic                    head_vld;
  logic [TIME_BITS-1:0]    dt;
  logic                    push, pop, apply_now, is_late;
  logic [N-1:0]            edge_word;

  assign req.req_ready = (count_q != FULL_CNT);
  assign push          = req.req_valid && req.req_ready;

  // The entry written on the previous edge is held back one cycle, so a
  // lone freshly pushed entry is not yet visible at the head.
  assign head     = mem_q[rd_ptr_q];
  assign head_vld = (count_q != '0) && !(count_q == CNT_ONE && push_q);
  assign dt       = head.t - time_q;
  assign apply_now = head_vld && (dt == '0);
  // MSB set means the head lies in the past half of the wrapping timeline.
  assign is_late   = head_vld && dt[TIME_BITS-1];
  assign pop       = apply_now || is_late;

  for (genvar i = 0; i < N; i++) begin : g_lane
    tagger_edge_gen_lane #(.BITS(BITS), .LANE(i)) u_lane (
      .subtime    (head.sub),
      .edge_level (head.lvl),
      .prev_level (line_q),
      .sample     (edge_word[i])
    );
  end

  always_comb begin
    time_d    = time_q + TIME_ONE;
    samples_d = {N{line_q}};
    line_d    = line_q;
    late_d    = is_late;
    push_d    = push;
    wr_ptr_d  = push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d  = pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    count_d   = count_q;
    if (push && !pop) count_d = count_q + CNT_ONE;
    if (!push && pop) count_d = count_q - CNT_ONE;
    if (apply_now) begin
      samples_d = edge_word;
      line_d    = head.lvl;
    end
`ifdef TAGGER_EDGE_GEN_LATE_APPLY_EN
    if (is_late) begin
      samples_d = {N{head.lvl}};
      line_d    = head.lvl;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      time_q    <= '0;
      samples_q <= '0;
      line_q    <= 1'b0;
      late_q    <= 1'b0;
      count_q   <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      push_q    <= 1'b0;
    end else begin
      time_q    <= time_d;
      samples_q <= samples_d;
      line_q    <= line_d;
      late_q    <= late_d;
      count_q   <= count_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      push_q    <= push_d;
    end
  end

  // Storage needs no reset: occupancy and pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= '{t: req.req_time, sub: req.req_subtime, lvl: req.req_level};
  end

  assign time_now   = time_q;
  assign samples    = samples_q;
  assign line_level = line_q;
  assign late       = late_q;
  assign fifo_count = count_q;
endmodule

// File: doc/tagger_edge_generator.md
# tagger_edge_generator

Transmit-side counterpart of the tagger input path. It accepts scheduled edge requests (coarse time, sub-clock subtime, new level) through a valid/ready port and queues them in a FIFO. At the scheduled clock it emits a per-clock sample word for an output serializer that drives the physical line. It is the inverse of the sampler-plus-subtime-converter chain: subtimes go in, a sampled line pattern comes out.

## Interface
- BITS, 3: subtime width; samples per clock N = 1<<BITS.
- TIME_BITS, 16: width of the coarse timestamp and of the free-running counter.
- DEPTH_LOG2, 3: FIFO depth = 1<<DEPTH_LOG2 entries.

- clk  in  1  single clock; all logic is on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- time_now  out  TIME_BITS  free-running coarse counter, for producers to use when scheduling.
- req_valid  in  1  edge request present.
- req_ready  out  1  FIFO can accept.
- req_time  in  TIME_BITS  coarse slot of the edge.
- req_subtime  in  BITS  sample index of the edge within the slot.
- req_level  in  1  line level from the edge onward.
- samples  out  N  serializer word; bit 0 is the earliest sample in time.
- line_level  out  1  level at the end of the current word.
- late  out  1  one-cycle pulse: the head request missed its slot.
- fifo_count  out  DEPTH_LOG2+1  occupancy.

## Operation
- **Counter.** `time_now` increments by 1 every clock and wraps modulo 2^TIME_BITS.
- **Request acceptance.**
  - A request is accepted when `req_valid && req_ready`.
  - `req_ready = (fifo_count != DEPTH)`, combinational from the registered count only. When the FIFO is full, a simultaneous pop does not raise ready.
  - Producers must issue requests in nondecreasing time order.
- **Head classification.** Each cycle with the FIFO non-empty, compute d = head.time − time_now (mod 2^TIME_BITS).
  - d == 0: apply the edge.
  - MSB of d set: the request is late.
  - Otherwise: wait.
- **Apply** (slot T = time_now):
  - `samples` bits [N−1:s] = head.level; bits [s−1:0] = `line_level`, where s = head.subtime.
  - `line_level` becomes head.level, and the head is popped.
  - At most one edge is applied per slot.
  - A request whose level equals `line_level` is still popped. It produces a constant word and no flag.
- **Idle slot.** `samples` = {N{line_level}}.
- **Late.** The head is popped and `late` is registered high for one cycle. Handling depends on TAGGER_EDGE_GEN_LATE_APPLY_EN (see Configuration).
- **Same slot.** A second request with the same time as an applied edge reaches the head one slot late and is handled as late.
- **Reset.** While `rst_n` is low, requests are ignored.

## Timing
- **Reset values:** time_now=0, samples=0, line_level=0, late=0, fifo_count=0, FIFO empty. Asynchronous reset applies immediately, including mid-operation; queued requests are discarded.
- **FIFO latency:** an entry accepted at edge k is visible at the head after edge k+1. With the FIFO empty, the minimum lead is req_time − time_now ≥ 2 at acceptance; less than that is reported as late.
- **Output latency:** the word for slot T is registered on the edge where time_now goes T→T+1. It is therefore valid while time_now == T+1.
- **Late flag:** `late` is high in the cycle after the late head was detected.
- **Counter wrap:** coarse time wraps. A request is "future" if it lies within 2^(TIME_BITS−1)−1 slots ahead of time_now; otherwise it is past.
- **fifo_count:** updates on the edge following each push or pop. A simultaneous push and pop leaves it unchanged.

## Configuration
- **TAGGER_EDGE_GEN_LATE_APPLY_EN defined:** a late head is applied in the current slot at subtime 0. The word is {N{head.level}}, and `line_level` updates.
- **Not defined:** a late head is dropped. `samples` and `line_level` are unaffected.
- In both cases the head is popped and `late` pulses.

## Test plan
All scenarios use BITS=3, TIME_BITS=16, DEPTH_LOG2=3.

- **Basic rising edge:** release reset; at time_now=2 push {10,3,1} → while time_now=11, samples=8'hF8 and line_level=1; from time_now=12, samples=8'hFF.
- **Falling edge:** push {12,0,0} → while time_now=13, samples=8'h00 and line_level=0.
- **Same slot, macro defined:** push {20,2,1} then {20,5,0} → time_now=21: samples=8'hFC; time_now=22: late=1, samples=8'h00, line_level=0.
- **Same slot, macro undefined:** same stimulus → time_now=22: late=1, samples=8'hFF, line_level=1.
- **Full FIFO:** hold req_valid with times ≥ time_now+1000 → exactly 8 accepted, fifo_count=8, req_ready=0. The 9th is accepted only after the first pop.
- **Wrap-around:** at time_now=65534 push {1,4,1} → no late pulse; while time_now=2, samples=8'hF0.
- **Reset mid-operation:** with 3 entries queued and line_level=1, pulse rst_n low → immediately fifo_count=0, samples=0, line_level=0, time_now=0. No queued edge appears after release.
